// File: rtl/pipe_cleaning_robot_top.sv
// Grid-world pipe-cleaning robot: 20x15 map with walls/barrier/trash, left-wall-following robot stepped per KEY[3] press.
// The 640x480@60 VGA view is registered, one CLOCK_50 cycle behind the pixel counters; there is no backpressure.
module pipe_cleaning_robot_top #(
  parameter int START_ROW = 7,
  parameter int START_COL = 0,
  parameter int START_DIR = 2
) (
  input  logic        CLOCK_50,
  input  logic [3:0]  KEY,
  input  logic [17:0] SW,
  input  logic        up_z,
  input  logic        down_y,
  input  logic        left_x,
  input  logic        right,
  input  logic        a_b,
  input  logic        selectSignal,
  input  logic        start_c,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_CLK,
  output logic [8:0]  LEDG,
  output logic [10:0] buttonsOut
);

  typedef enum logic [2:0] {
    ST_SEARCH  = 3'd0,
    ST_ROTATE  = 3'd1,
    ST_FOLLOW  = 3'd2,
    ST_STANDBY = 3'd3,
    ST_FIRST   = 3'd4,
    ST_RESET   = 3'd5
  } act_state_e;

  localparam logic [3:0] DIR_N = 4'd0;
  localparam logic [3:0] DIR_S = 4'd1;
  localparam logic [3:0] DIR_E = 4'd2;
  localparam logic [3:0] DIR_W = 4'd3;

  localparam logic [299:0] TRASH_INIT = (300'd1 << 145) | (300'd1 << 70) | (300'd1 << 235);

  localparam logic [23:0] C_ROBOT   = 24'h00FF00;
  localparam logic [23:0] C_WALL    = 24'h808080;
  localparam logic [23:0] C_BARRIER = 24'hFF0000;
  localparam logic [23:0] C_TRASH   = 24'h8B4513;

  function automatic logic is_wall(input logic [4:0] r, input logic [4:0] c);
    return ((r == 5'd0) || (r == 5'd14) || (c == 5'd0) || (c == 5'd19)) &&
           !((r == 5'd7) && (c == 5'd0));
  endfunction

  function automatic logic is_barrier(input logic [4:0] r, input logic [4:0] c);
    return (r == 5'd7) && (c == 5'd12);
  endfunction

  function automatic logic [8:0] cell_idx(input logic [4:0] r, input logic [4:0] c);
    return ({4'd0, r} * 9'd20) + {4'd0, c};
  endfunction

  // 6-bit coordinates: stepping off row/col 0 wraps to 63, which the range check reports as off-grid.
  function automatic logic [11:0] neighbour(input logic [4:0] r, input logic [4:0] c, input logic [3:0] d);
    logic [5:0] nr;
    logic [5:0] nc;
    nr = {1'b0, r};
    nc = {1'b0, c};
    case (d)
      DIR_N:   nr = nr - 6'd1;
      DIR_S:   nr = nr + 6'd1;
      DIR_E:   nc = nc + 6'd1;
      default: nc = nc - 6'd1;
    endcase
    return {nr, nc};
  endfunction

  logic        rst_n;
  logic        pclk_q, pclk_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        hs_q, hs_d, vs_q, vs_d;
  logic [23:0] rgb_q, rgb_d;
  logic        sw_meta_q, sw_meta_d, mode_q, mode_d;
  logic        k3_meta_q, k3_meta_d, k3_sync_q, k3_sync_d, k3_prev_q, k3_prev_d;
  logic [4:0]  row_q, row_d, col_q, col_d;
  logic [3:0]  dir_q, dir_d;
  logic [299:0] trash_q, trash_d;
  act_state_e  act_state_q, act_state_d, next_state;

  logic        step, head, left_blk, barrier, under;
  logic [11:0] fwd_cell, left_cell;
  logic        fwd_off, left_off;
  logic [3:0]  left_dir, right_dir;
  logic        do_fwd, do_left, do_right, do_clear;
  logic [8:0]  cur_idx;
  logic [4:0]  cell_r, cell_c;
  logic        unused_inputs;

  assign rst_n         = KEY[0] & KEY[1];
  assign unused_inputs = ^{SW[17:1], KEY[2]};

  always_comb begin
    case (dir_q)
      DIR_N:   begin left_dir = DIR_W; right_dir = DIR_E; end
      DIR_S:   begin left_dir = DIR_E; right_dir = DIR_W; end
      DIR_E:   begin left_dir = DIR_N; right_dir = DIR_S; end
      default: begin left_dir = DIR_S; right_dir = DIR_N; end
    endcase
    fwd_cell  = neighbour(row_q, col_q, dir_q);
    left_cell = neighbour(row_q, col_q, left_dir);
    fwd_off   = (fwd_cell[11:6] > 6'd14) || (fwd_cell[5:0] > 6'd19);
    left_off  = (left_cell[11:6] > 6'd14) || (left_cell[5:0] > 6'd19);
    barrier   = !fwd_off && is_barrier(fwd_cell[10:6], fwd_cell[4:0]);
    head      = fwd_off || is_wall(fwd_cell[10:6], fwd_cell[4:0]) || barrier;
    left_blk  = left_off || is_wall(left_cell[10:6], left_cell[4:0]);
    cur_idx   = cell_idx(row_q, col_q);
    under     = trash_q[cur_idx];
  end

  always_comb begin
    next_state = act_state_q;
    do_fwd     = 1'b0;
    do_left    = 1'b0;
    do_right   = 1'b0;
    do_clear   = 1'b0;
    if (!mode_q && (act_state_q != ST_RESET)) begin
      next_state = ST_STANDBY;
    end else begin
      case (act_state_q)
        ST_RESET:   next_state = ST_STANDBY;
        ST_STANDBY: next_state = ST_FIRST;
        ST_FIRST: begin
          do_fwd     = !head;
          next_state = ST_SEARCH;
        end
        ST_SEARCH: begin
          if (under) begin
            next_state = ST_FOLLOW;
          end else if (!left_blk) begin
            do_left    = 1'b1;
            next_state = ST_FOLLOW;
          end else if (!head) begin
            do_fwd = 1'b1;
          end else begin
            next_state = ST_ROTATE;
          end
        end
        ST_ROTATE: begin
          do_right   = 1'b1;
          next_state = ST_SEARCH;
        end
        ST_FOLLOW: begin
          do_clear   = under;
          do_fwd     = !under && !head;
          next_state = ST_SEARCH;
        end
        default: next_state = ST_STANDBY;
      endcase
    end
  end

  // Robot state only changes on the edge that sees a synchronised KEY[3] falling edge.
  always_comb begin
    sw_meta_d   = SW[0];
    mode_d      = sw_meta_q;
    k3_meta_d   = KEY[3];
    k3_sync_d   = k3_meta_q;
    k3_prev_d   = k3_sync_q;
    step        = k3_prev_q & ~k3_sync_q;
    act_state_d = act_state_q;
    row_d       = row_q;
    col_d       = col_q;
    dir_d       = dir_q;
    trash_d     = trash_q;
    if (step) begin
      act_state_d = next_state;
      if (do_fwd) begin
        row_d = fwd_cell[10:6];
        col_d = fwd_cell[4:0];
      end
      if (do_left)  dir_d = left_dir;
      if (do_right) dir_d = right_dir;
      if (do_clear) trash_d[cur_idx] = 1'b0;
    end
  end

  always_comb begin
    pclk_d = ~pclk_q;
    x_d    = x_q;
    y_d    = y_q;
    if (pclk_q) begin
      if (x_q == 10'd799) begin
        x_d = '0;
        y_d = (y_q == 10'd524) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    hs_d   = !((x_q >= 10'd656) && (x_q <= 10'd751));
    vs_d   = !((y_q >= 10'd490) && (y_q <= 10'd491));
    cell_r = y_q[9:5];
    cell_c = x_q[9:5];
    rgb_d  = '0;
    if ((x_q < 10'd640) && (y_q < 10'd480)) begin
      if ((cell_r == row_q) && (cell_c == col_q))   rgb_d = C_ROBOT;
      else if (is_wall(cell_r, cell_c))             rgb_d = C_WALL;
      else if (is_barrier(cell_r, cell_c))          rgb_d = C_BARRIER;
      else if (trash_q[cell_idx(cell_r, cell_c)])   rgb_d = C_TRASH;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      pclk_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      rgb_q       <= '0;
      sw_meta_q   <= 1'b0;
      mode_q      <= 1'b0;
      k3_meta_q   <= 1'b1;
      k3_sync_q   <= 1'b1;
      k3_prev_q   <= 1'b1;
      row_q       <= 5'(START_ROW);
      col_q       <= 5'(START_COL);
      dir_q       <= 4'(START_DIR);
      trash_q     <= TRASH_INIT;
      act_state_q <= ST_RESET;
    end else begin
      pclk_q      <= pclk_d;
      x_q         <= x_d;
      y_q         <= y_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      rgb_q       <= rgb_d;
      sw_meta_q   <= sw_meta_d;
      mode_q      <= mode_d;
      k3_meta_q   <= k3_meta_d;
      k3_sync_q   <= k3_sync_d;
      k3_prev_q   <= k3_prev_d;
      row_q       <= row_d;
      col_q       <= col_d;
      dir_q       <= dir_d;
      trash_q     <= trash_d;
      act_state_q <= act_state_d;
    end
  end

  assign VGA_CLK    = pclk_q;
  assign VGA_HS     = hs_q;
  assign VGA_VS     = vs_q;
  assign VGA_R      = rgb_q[23:16];
  assign VGA_G      = rgb_q[15:8];
  assign VGA_B      = rgb_q[7:0];
  assign LEDG       = {under, dir_q, mode_q, act_state_q};
  assign buttonsOut = {4'b0, start_c, selectSignal, a_b, right, left_x, down_y, up_z};

endmodule

// File: tb/tb_pipe_cleaning_robot_top.sv
`timescale 1ns/1ps
module tb_pipe_cleaning_robot_top;

  logic        clk = 1'b0;
  always #10 clk = ~clk;

  logic [3:0]  key;
  logic [17:0] sw;
  logic [6:0]  btn;
  logic        hs [2];
  logic        vs [2];
  logic        vclk [2];
  logic [7:0]  vr [2];
  logic [7:0]  vg [2];
  logic [7:0]  vb [2];
  logic [8:0]  ledg [2];
  logic [10:0] bout [2];

  pipe_cleaning_robot_top dut_a (
    .CLOCK_50(clk), .KEY(key), .SW(sw),
    .up_z(btn[0]), .down_y(btn[1]), .left_x(btn[2]), .right(btn[3]),
    .a_b(btn[4]), .selectSignal(btn[5]), .start_c(btn[6]),
    .VGA_HS(hs[0]), .VGA_VS(vs[0]), .VGA_R(vr[0]), .VGA_G(vg[0]), .VGA_B(vb[0]),
    .VGA_CLK(vclk[0]), .LEDG(ledg[0]), .buttonsOut(bout[0])
  );

  // Second robot starts one cell west of the (7,5) trash so the cleaning path is exercised.
  pipe_cleaning_robot_top #(.START_ROW(7), .START_COL(4), .START_DIR(2)) dut_b (
    .CLOCK_50(clk), .KEY(key), .SW(sw),
    .up_z(btn[0]), .down_y(btn[1]), .left_x(btn[2]), .right(btn[3]),
    .a_b(btn[4]), .selectSignal(btn[5]), .start_c(btn[6]),
    .VGA_HS(hs[1]), .VGA_VS(vs[1]), .VGA_R(vr[1]), .VGA_G(vg[1]), .VGA_B(vb[1]),
    .VGA_CLK(vclk[1]), .LEDG(ledg[1]), .buttonsOut(bout[1])
  );

  wire rst_tb = key[0] & key[1];

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 0;

  // ---------------- behavioural reference model ----------------
  int start_col_m [2] = '{0, 4};
  int m_row [2];
  int m_col [2];
  int m_dir [2];
  int m_st [2];
  bit m_trash [2][300];
  int ncyc;
  int k1, k2, k3, s1, s2;
  bit e_hs, e_vs;
  bit [23:0] e_rgb [2];

  function automatic bit on_grid(int r, int c);
    return r >= 0 && r < 15 && c >= 0 && c < 20;
  endfunction
  function automatic bit wall_at(int r, int c);
    return on_grid(r, c) && (r == 0 || r == 14 || c == 0 || c == 19) && !(r == 7 && c == 0);
  endfunction
  function automatic int dr_of(int d);
    return (d == 0) ? -1 : (d == 1) ? 1 : 0;
  endfunction
  function automatic int dc_of(int d);
    return (d == 2) ? 1 : (d == 3) ? -1 : 0;
  endfunction
  function automatic int left_of(int d);
    return (d == 0) ? 3 : (d == 3) ? 1 : (d == 1) ? 2 : 0;
  endfunction
  function automatic int right_of(int d);
    return (d == 0) ? 2 : (d == 2) ? 1 : (d == 1) ? 3 : 0;
  endfunction
  function automatic bit m_head(int i);
    int fr, fc;
    fr = m_row[i] + dr_of(m_dir[i]);
    fc = m_col[i] + dc_of(m_dir[i]);
    return !on_grid(fr, fc) || wall_at(fr, fc) || (fr == 7 && fc == 12);
  endfunction
  function automatic bit m_left(int i);
    int ld, lr, lc;
    ld = left_of(m_dir[i]);
    lr = m_row[i] + dr_of(ld);
    lc = m_col[i] + dc_of(ld);
    return !on_grid(lr, lc) || wall_at(lr, lc);
  endfunction
  function automatic bit m_under(int i);
    return m_trash[i][m_row[i] * 20 + m_col[i]];
  endfunction
  function automatic bit [23:0] m_color(int i, int x, int y);
    int cr, cc;
    if (x >= 640 || y >= 480) return 24'h0;
    cr = y / 32;
    cc = x / 32;
    if (cr == m_row[i] && cc == m_col[i]) return 24'h00FF00;
    if (wall_at(cr, cc)) return 24'h808080;
    if (cr == 7 && cc == 12) return 24'hFF0000;
    if (m_trash[i][cr * 20 + cc]) return 24'h8B4513;
    return 24'h0;
  endfunction

  task automatic m_reset();
    ncyc = 0; k1 = 1; k2 = 1; k3 = 1; s1 = 0; s2 = 0;
    e_hs = 1; e_vs = 1;
    for (int i = 0; i < 2; i++) begin
      m_row[i] = 7; m_col[i] = start_col_m[i]; m_dir[i] = 2; m_st[i] = 5; e_rgb[i] = 0;
      for (int j = 0; j < 300; j++) m_trash[i][j] = 0;
      m_trash[i][7 * 20 + 5] = 1;
      m_trash[i][3 * 20 + 10] = 1;
      m_trash[i][11 * 20 + 15] = 1;
    end
  endtask

  task automatic m_fwd(int i);
    m_row[i] = m_row[i] + dr_of(m_dir[i]);
    m_col[i] = m_col[i] + dc_of(m_dir[i]);
  endtask

  task automatic m_step(int i, int mode);
    bit hd, lf, un;
    hd = m_head(i); lf = m_left(i); un = m_under(i);
    if (mode == 0 && m_st[i] != 5) begin
      m_st[i] = 3;
      return;
    end
    case (m_st[i])
      5: m_st[i] = 3;
      3: m_st[i] = 4;
      4: begin if (!hd) m_fwd(i); m_st[i] = 0; end
      0: begin
        if (un) m_st[i] = 2;
        else if (!lf) begin m_dir[i] = left_of(m_dir[i]); m_st[i] = 2; end
        else if (!hd) m_fwd(i);
        else m_st[i] = 1;
      end
      1: begin m_dir[i] = right_of(m_dir[i]); m_st[i] = 0; end
      default: begin
        if (un) m_trash[i][m_row[i] * 20 + m_col[i]] = 0;
        else if (!hd) m_fwd(i);
        m_st[i] = 0;
      end
    endcase
  endtask

  // Inputs reach the robot logic two clocks late; a press is a 1 -> 0 change in that delayed view.
  initial forever begin
    @(posedge clk or negedge rst_tb);
    if (!rst_tb) begin
      m_reset();
    end else begin
      int p, x, y;
      p = ncyc / 2;
      x = p % 800;
      y = (p / 800) % 525;
      e_hs = !(x >= 656 && x <= 751);
      e_vs = !(y >= 490 && y <= 491);
      for (int i = 0; i < 2; i++) e_rgb[i] = m_color(i, x, y);
      if (k2 == 0 && k3 == 1)
        for (int i = 0; i < 2; i++) m_step(i, s2);
      k3 = k2; k2 = k1; k1 = int'(key[3]);
      s2 = s1; s1 = int'(sw[0]);
      ncyc++;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] got %h expected %h at %0t", nm, i, act, exp, $time);
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("ledg", i, ledg[i], {m_under(i), 4'(m_dir[i]), 1'(s2), 3'(m_st[i])});
        chk("vga_clk", i, vclk[i], ncyc % 2);
        chk("hsync", i, hs[i], e_hs);
        chk("vsync", i, vs[i], e_vs);
        chk("rgb", i, {vr[i], vg[i], vb[i]}, e_rgb[i]);
        chk("buttons", i, bout[i], {4'b0, btn});
      end
    end
  end

  task automatic press(int hold);
    key[3] = 1'b0;
    repeat (hold) @(posedge clk);
    #1 key[3] = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic press_chk(string nm, logic [8:0] ea, logic [8:0] eb);
    press(4);
    chk(nm, 0, ledg[0], ea);
    chk(nm, 1, ledg[1], eb);
  endtask

  initial begin
    key = 4'b1111; sw = '0; btn = '0;
    @(posedge clk); #1 key[0] = 1'b0;
    chk_en = 1'b1;
    sw[0] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset_ledg", 0, ledg[0], 9'h025);
    chk("reset_ledg", 1, ledg[1], 9'h025);
    chk("reset_rgb", 0, {vr[0], vg[0], vb[0]}, 24'h0);
    @(posedge clk); #1 key[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("pixel00_grey", 0, {vr[0], vg[0], vb[0]}, 24'h808080);
    chk("first_vga_clk", 0, vclk[0], 1);
    @(posedge clk); #1;

    press_chk("step1_standby", 9'h02B, 9'h02B);
    press_chk("step2_first", 9'h02C, 9'h02C);
    press_chk("step3_move", 9'h028, 9'h128);
    press_chk("step4_turn_or_remove", 9'h00A, 9'h12A);
    press_chk("step5_fwd_or_clear", 9'h008, 9'h028);

    // Long run without reset so the pixel checks cover the top cell rows and many sync pulses.
    while (ncyc < 53000) begin
      btn = 7'($urandom);
      sw[17:1] = 17'($urandom);
      sw[0] = ($urandom_range(0, 9) != 0);
      key[2] = 1'($urandom_range(0, 1));
      press($urandom_range(4, 12));
    end

    for (int n = 0; n < 300; n++) begin
      btn = 7'($urandom);
      sw[0] = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 24) == 0) begin
        int w;
        w = $urandom_range(0, 1);
        key[w] = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 key[w] = 1'b1;
      end
      press($urandom_range(4, 9));
    end

    sw[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    press(4);
    chk("mode0_standby", 0, ledg[0][2:0], 3);
    chk("mode0_standby", 1, ledg[1][2:0], 3);
    key[1] = 1'b0;
    sw[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("key1_reset", 0, ledg[0], 9'h025);
    chk("key1_reset", 1, ledg[1], 9'h025);
    @(posedge clk); #1 key[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    press_chk("restart_standby", 9'h02B, 9'h02B);
    press_chk("restart_first", 9'h02C, 9'h02C);
    press_chk("trash_restored", 9'h028, 9'h128);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
